// File: rtl/axis_pkg.sv
// Shared types and constants for the memory-backed AXI-Stream master.
// Holds the FSM state encoding, the default data width and the LFSR seed.
package axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } axis_state_t;

    localparam int         DATA_W_DEFAULT = 32;
    localparam logic [5:0] LFSR_SEED      = 6'b000011;

endpackage

// File: rtl/axis_lfsr6.sv
// 6-bit XNOR-feedback LFSR that gates tvalid when AXIS_MASTER_LFSR_THROTTLE_EN is defined.
// The register only moves when 'advance' is high, so it holds while a beat is stalled.
module axis_lfsr6
    import axis_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       advance,
    output logic [5:0] state
);

    // x^6 + x^5 + 1 with XNOR feedback; all-ones is the lock-up state, which the seed avoids
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= {state[4:0], state[5] ^ state[4] ^ 1'b1};
        end
    end

endmodule

// File: rtl/axis_master_mem.sv
// Streams a packet out of a local word buffer over AXI-Stream on each start request.
// Optional tvalid throttling is enabled by defining AXIS_MASTER_LFSR_THROTTLE_EN.
module axis_master_mem
    import axis_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEFAULT,
    parameter  int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] pkt_len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [STRB_W-1:0] m_axis_tstrb,
    output logic [STRB_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    axis_state_t       state;
    axis_state_t       state_next;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] len_latched;
    logic [ADDR_W-1:0] last_idx;
    logic              beat;
    logic              stream_valid;
    logic [DATA_W-1:0] mem [DEPTH];

    // Buffer is not reset and is frozen while a packet is being sent
    always_ff @(posedge m_axis_aclk) begin
        if (wr_en && (state == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef AXIS_MASTER_LFSR_THROTTLE_EN
    logic [5:0] lfsr;

    axis_lfsr6 u_lfsr (
        .clk     (m_axis_aclk),
        .resetn  (m_axis_aresetn),
        .advance (!(m_axis_tvalid && !m_axis_tready)),
        .state   (lfsr)
    );

    assign stream_valid = (state == STREAM) && lfsr[5];
`else
    assign stream_valid = (state == STREAM);
`endif

    // Length 0 wraps to DEPTH-1 here, so it naturally means a full-buffer packet
    assign last_idx = len_latched - ADDR_W'(1);
    assign beat     = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = (state == STREAM);
        m_axis_tvalid = stream_valid;
        m_axis_tlast  = stream_valid && (rd_ptr == last_idx);
        m_axis_tdata  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                m_axis_tdata = mem[rd_ptr];
                if (beat && m_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rd_ptr      <= '0;
            len_latched <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state == STREAM) && beat && m_axis_tlast;
            if ((state == IDLE) && start) begin
                rd_ptr      <= '0;
                len_latched <= pkt_len;
            end else if ((state == STREAM) && beat) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    assign m_axis_tstrb = '1;
    assign m_axis_tkeep = '1;

endmodule

// File: tb/tb_axis_master_mem.sv
// Directed self-checking bench for axis_master_mem (DATA_W=32, DEPTH=128).
// Cycle-exact latency checks are skipped when AXIS_MASTER_LFSR_THROTTLE_EN is defined.
module tb_axis_master_mem;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [6:0]  pkt_len;
    logic        busy;
    logic        done;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    logic [31:0] mem_model [128];
    int          checks;
    int          passes;
    int          got;
    int          errs;

    axis_master_mem #(.DATA_W(32), .DEPTH(128)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .pkt_len        (pkt_len),
        .busy           (busy),
        .done           (done),
        .m_axis_tdata   (tdata),
        .m_axis_tstrb   (tstrb),
        .m_axis_tkeep   (tkeep),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic writeWord(input int addr, input logic [31:0] value);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_data = value;
        mem_model[addr] = value;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulse start for one edge; leaves the bench at the negedge after the start edge
    task automatic applyStimulus(input logic [6:0] len, input string tag);
        @(negedge clk);
        pkt_len = len;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
`ifndef AXIS_MASTER_LFSR_THROTTLE_EN
        checkOutput({tag, "_tvalid_latency"}, 32'(tvalid), 32'd1);
`endif
    endtask

    // Scoreboard receiver: checks order, tlast placement and stall stability
    task automatic receivePacket(input int nbeats, input int stallBeat, input int stallCycles,
                                 input bit randReady, input bit poke,
                                 output int nGot, output int nErr);
        int          cyc;
        int          stalls;
        bit          holding;
        logic [31:0] heldData;
        logic        heldLast;
        nGot = 0; nErr = 0; cyc = 0; stalls = 0; holding = 0;
        heldData = '0; heldLast = 1'b0;
        while (busy && cyc < 3000) begin
            if (holding && (tvalid !== 1'b1 || tdata !== heldData || tlast !== heldLast)) nErr++;
`ifndef AXIS_MASTER_LFSR_THROTTLE_EN
            if (tvalid !== 1'b1) nErr++;
`endif
            if (tvalid && nGot < nbeats) begin
                if (tdata !== mem_model[nGot]) nErr++;
                if (tlast !== (nGot == nbeats - 1)) nErr++;
            end else if (tvalid) begin
                nErr++;
            end
            if (poke && cyc == 0) begin
                wr_en = 1'b1; wr_addr = 7'd5; wr_data = 32'hDEAD; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (tvalid && nGot == stallBeat && stalls < stallCycles) begin
                tready = 1'b0;
                stalls++;
            end else if (randReady) begin
                tready = 1'($urandom_range(0, 1));
            end else begin
                tready = 1'b1;
            end
            holding  = tvalid && !tready;
            heldData = tdata;
            heldLast = tlast;
            if (tvalid && tready) nGot++;
            @(negedge clk);
            cyc++;
        end
        tready = 1'b1;
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int transfers;
        int lasts;
        int dones;
        int pos;
        checks = 0; passes = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; pkt_len = '0; tready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(tlast), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_tdata", tdata, 32'd0);
        checkOutput("tkeep_ones", 32'(tkeep), 32'hF);
        checkOutput("tstrb_ones", 32'(tstrb), 32'hF);
        rst_n = 1'b1;

        // Fill buffer with mem[i] = i
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 7'(i); wr_data = 32'(i);
            mem_model[i] = 32'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checkOutput("idle_tvalid", 32'(tvalid), 32'd0);

        $display("[TB] full 128-beat packet");
        applyStimulus(7'd0, "full");
        receivePacket(128, -1, 0, 1'b0, 1'b0, got, errs);
        checkOutput("full_beats", 32'(got), 32'd128);
        checkOutput("full_errs", 32'(errs), 32'd0);
        checkDone("full");

        $display("[TB] 4-beat packet with stall on beat 2");
        applyStimulus(7'd4, "stall");
        receivePacket(4, 2, 3, 1'b0, 1'b0, got, errs);
        checkOutput("stall_beats", 32'(got), 32'd4);
        checkOutput("stall_errs", 32'(errs), 32'd0);
        checkDone("stall");

        $display("[TB] start held high, 2-beat packets");
        @(negedge clk);
        pkt_len = 7'd2; start = 1'b1;
        transfers = 0; lasts = 0; dones = 0; pos = 0; errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (tvalid && tready) begin
                if (tdata !== mem_model[pos]) errs++;
                if (tlast !== (pos == 1)) errs++;
                transfers++;
                if (pos == 1) begin
                    lasts++;
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
        start = 1'b0;
        checkOutput("hold_errs", 32'(errs), 32'd0);
`ifndef AXIS_MASTER_LFSR_THROTTLE_EN
        checkOutput("hold_transfers", 32'(transfers), 32'd20);
        checkOutput("hold_lasts", 32'(lasts), 32'd10);
        checkOutput("hold_dones", 32'(dones), 32'd10);
`endif
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        checkOutput("hold_end_idle", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("hold_stay_idle", 32'(busy), 32'd0);

        $display("[TB] reset in the middle of a packet");
        applyStimulus(7'd0, "mid");
        repeat (50) @(negedge clk);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("mid_rst_tlast", 32'(tlast), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_tdata", tdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(7'd0, "after_rst");
        receivePacket(128, -1, 0, 1'b0, 1'b0, got, errs);
        checkOutput("after_rst_beats", 32'(got), 32'd128);
        checkOutput("after_rst_errs", 32'(errs), 32'd0);
        checkDone("after_rst");

        $display("[TB] random tready scoreboard");
        applyStimulus(7'd0, "rand");
        receivePacket(128, -1, 0, 1'b1, 1'b0, got, errs);
        checkOutput("rand_beats", 32'(got), 32'd128);
        checkOutput("rand_errs", 32'(errs), 32'd0);
        checkDone("rand");

        $display("[TB] write and start while busy are dropped");
        applyStimulus(7'd8, "poke");
        receivePacket(8, -1, 0, 1'b0, 1'b1, got, errs);
        checkOutput("poke_beats", 32'(got), 32'd8);
        checkOutput("poke_errs", 32'(errs), 32'd0);
        checkDone("poke");
        checkOutput("poke_no_restart", 32'(busy), 32'd0);

        writeWord(5, 32'hDEAD);
        applyStimulus(7'd8, "idle_wr");
        receivePacket(8, -1, 0, 1'b0, 1'b0, got, errs);
        checkOutput("idle_wr_beats", 32'(got), 32'd8);
        checkOutput("idle_wr_errs", 32'(errs), 32'd0);
        checkDone("idle_wr");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_master_mem.md
AXIS_MASTER_MEM -- requirements
Module: axis_master_mem

Interface
REQ-001 Parameter DATA_W, default 32, stream data width in bits (multiple of 8).
REQ-002 Parameter DEPTH, default 128, packet buffer depth in words (power of two); ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: m_axis_aclk and m_axis_aresetn.
REQ-004 m_axis_aclk  in  1  clock; all state changes on its rising edge.
REQ-005 m_axis_aresetn  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  buffer write strobe.
REQ-007 wr_addr  in  ADDR_W  buffer write address.
REQ-008 wr_data  in  DATA_W  buffer write data.
REQ-009 start  in  1  begin a packet (level-sampled in IDLE).
REQ-010 pkt_len  in  ADDR_W  packet length in words; 0 means DEPTH.
REQ-011 busy  out  1  high while a packet is in progress.
REQ-012 done  out  1  one-cycle pulse after the final beat is accepted.
REQ-013 m_axis_tdata  out  DATA_W  stream data.
REQ-014 m_axis_tstrb  out  DATA_W/8  byte strobes, all ones.
REQ-015 m_axis_tkeep  out  DATA_W/8  byte keeps, all ones.
REQ-016 m_axis_tvalid  out  1  beat valid.
REQ-017 m_axis_tready  in  1  downstream ready.
REQ-018 m_axis_tlast  out  1  marks the final beat of a packet.

Function
REQ-019 The FSM SHALL have two states: IDLE and STREAM.
REQ-020 IDLE->STREAM: start=1 at a clock edge; the block SHALL latch pkt_len at that edge and clear rd_ptr to 0.
REQ-021 STREAM: m_axis_tdata SHALL equal mem[rd_ptr]; a beat transfers at an edge where tvalid=1 and tready=1; each transfer SHALL increment rd_ptr by 1.
REQ-022 m_axis_tlast SHALL equal tvalid AND (rd_ptr == latched_len-1), computed modulo DEPTH so that length 0 ends at rd_ptr=DEPTH-1.
REQ-023 STREAM->IDLE: on the transfer with tlast=1; done SHALL be 1 in the following cycle only.
REQ-024 Latency: with throttling compiled out, tvalid SHALL rise in the cycle after the start edge and stay high through the packet.
REQ-025 Once tvalid=1 with tready=0, tvalid, tdata and tlast SHALL hold unchanged until the transfer.
REQ-026 busy SHALL equal (state==STREAM).
REQ-027 A start pulse while busy SHALL be ignored; back-to-back packets are allowed: start high in the IDLE cycle after done begins the next packet.
REQ-028 wr_en SHALL write mem[wr_addr] only in IDLE; writes while busy SHALL be dropped.
REQ-029 tvalid SHALL be 0 in IDLE.

Reset
REQ-030 Assertion of m_axis_aresetn low SHALL immediately force state=IDLE, rd_ptr=0, tvalid=0, tlast=0, busy=0, done=0 and tdata=0, including in the middle of a packet.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 On deassertion, the first start SHALL be honoured no earlier than the first edge after deassertion.

Configuration
REQ-033 Macro AXIS_MASTER_LFSR_THROTTLE_EN defined: tvalid = STREAM AND lfsr[5]; 6-bit LFSR, seed 6'b000011, next lfsr[0] = lfsr[5]^lfsr[4]^1, shift left; advance only when NOT (tvalid=1 AND tready=0).
REQ-034 Macro undefined: no LFSR; tvalid = (state==STREAM).

Structure
REQ-035 A shared package axis_pkg SHALL hold the FSM state enum {IDLE, STREAM}, the DATA_W default and the LFSR seed constant.
REQ-036 The LFSR throttle SHALL be a sub-module axis_lfsr6 (inputs: clk, resetn, advance; output: 6-bit state), instantiated only under the macro.

Verification
REQ-037 Load mem[i]=i for i=0..127, pkt_len=0, tready=1, start pulse -> 128 beats with tdata 0..127, tlast only on 127, done one cycle later.
REQ-038 pkt_len=4, tready low for 3 cycles on beat 2 -> tdata=2 with tvalid held stable for 3 cycles; tlast on tdata=3.
REQ-039 Start held high through the packet with pkt_len=2 -> exactly one packet per IDLE entry; start pulses while busy produce no extra beats.
REQ-040 Reset asserted at beat 50 of a 128-beat packet -> tvalid/tlast/busy 0 asynchronously; the next start sends from tdata 0.
REQ-041 wr_en to addr 5 with value 0xDEAD during STREAM -> beat 5 keeps its old value; the same write in IDLE -> 0xDEAD on the next packet.
REQ-042 With AXIS_MASTER_LFSR_THROTTLE_EN and random tready -> the scoreboard receives 0..127 in order with no drops or duplicates.
